st_sp_sequencer: RTL
====================

// Module: st_sp_sequencer
// PURPOSE
//  Owns the architectural stack pointer (SP) and sequences the combinational ST_datapath stack adder.
//  Accepts stack commands over a valid/ready handshake and drives the adder's op_sel/immed7/immed8/data_in inputs.
//  PUSH/POP register lists expand to one word-sized memory access per listed register.
//  Sits between instruction decode and the data-memory port.
// PARAMETERS
//  SP_RESET  32'h0000_1000  SP value after reset
//  SP_LIMIT  32'h0000_0800  lowest legal SP; a PUSH word below it faults
// PORTS
//  clk           in   1   system clock, all state on rising edge
//  reset         in   1   asynchronous, active-high reset
//  cmd_valid     in   1   command present
//  cmd_ready     out  1   sequencer can accept (IDLE only)
//  cmd_op        in   8   one-hot opcode: NOP=00 PUSH=01 POP=02 ADDSP=04 SUBSP=08 MOVSP=10 ADDS=20 LDRSP=40 STRSP=80
//  cmd_reglist   in   8   PUSH/POP register mask, bit i = r[i]
//  cmd_immed7    in   7   ADDSP/SUBSP word offset
//  cmd_immed8    in   8   ADDS/LDRSP/STRSP word offset
//  cmd_data      in   32  MOVSP new SP value
//  dp_op_sel     out  8   to datapath op_sel
//  dp_immed7     out  7   to datapath immed7 (latched)
//  dp_immed8     out  8   to datapath immed8 (latched)
//  dp_data_in    out  32  to datapath data_in; always equals sp
//  dp_data_out   in   32  datapath result
//  mem_req       out  1   memory access request
//  mem_we        out  1   1=write (PUSH/STRSP), 0=read (POP/LDRSP)
//  mem_addr      out  32  word address
//  mem_reg       out  3   register index being transferred
//  mem_ack       in   1   access complete this cycle
//  sp            out  32  current SP
//  res_valid     out  1   1-cycle pulse: ADDS result on res_data
//  res_data      out  32  ADDS result (SP + immed8*4)
//  done          out  1   1-cycle pulse: command retired
//  fault         out  1   1-cycle pulse with done: PUSH hit SP_LIMIT
// BEHAVIOUR
//  Reset (async, any state):
//   - sp=SP_RESET, state=IDLE.
//   - cmd_ready=1; dp_op_sel=NOP; dp_immed7=0; dp_immed8=0.
//   - mem_req=mem_we=0; mem_addr=0; mem_reg=0; res_valid=done=fault=0; res_data=0.
//   - An in-flight command is dropped; no done pulse.
//  States: IDLE, EXEC, MEM, DONE.
//   - IDLE: cmd_ready=1, dp_op_sel=NOP. On cmd_valid, latch op/reglist/immeds/data.
//       PUSH/POP with nonzero reglist -> MEM; every other op -> EXEC.
//   - EXEC (1 cycle): dp_op_sel=latched op, then -> DONE (LDRSP/STRSP -> MEM). Update at exit edge:
//       ADDSP/SUBSP: sp <= dp_data_out (mod 2^32, no fault).
//       MOVSP: sp <= cmd_data.
//       ADDS: res_data <= dp_data_out, res_valid in DONE cycle; sp unchanged.
//       NOP, PUSH/POP with reglist=0, non-one-hot op: nothing changes.
//   - MEM: mem_req=1 until mem_ack; mem_addr/mem_we/mem_reg held stable while waiting.
//       PUSH: registers highest index first. dp_op_sel=PUSH, mem_addr=dp_data_out (sp-4).
//         On ack: sp <= sp-4, clear bit. If sp-4 < SP_LIMIT (unsigned): no request, fault, -> DONE, sp keeps last legal value.
//       POP: registers lowest index first. dp_op_sel=POP, mem_addr=sp.
//         On ack: sp <= dp_data_out (sp+4), clear bit.
//       LDRSP/STRSP: dp_op_sel=op, mem_addr=dp_data_out, mem_reg=0; single access; sp unchanged.
//       Remaining mask empty after an ack -> DONE. Next access starts the following cycle.
//   - DONE (1 cycle): done=1 (plus res_valid/fault as above), dp_op_sel=NOP, then -> IDLE.
//  Timing: a non-memory op takes 3 cycles accept-to-accept. N-register PUSH/POP with zero-wait ack: N+2.
//  sp wraps modulo 2^32 on POP/ADDSP/SUBSP; only PUSH is limit-checked.
//  mem_ack outside MEM is ignored; cmd_valid outside IDLE is ignored (cmd_ready=0).
// TESTING
//  1. reset with sp=SP_RESET; ADDSP immed7=3 -> sp=0x100C, done one cycle 2 cycles after accept.
//  2. PUSH reglist=8'b1000_0101, ack each cycle -> writes r7@0xFFC, r2@0xFF8, r0@0xFF4; sp=0xFF4; done.
//  3. POP reglist=8'b0000_0011 from sp=0xFF8, ack delayed 2 cycles -> r0@0xFF8, r1@0xFFC, addr stable; sp=0x1000.
//  4. MOVSP 0x804, then PUSH reglist=0x03 -> r1@0x800 written, r0 not issued; fault+done; sp=0x800.
//  5. ADDS immed8=0xFF at sp=0x1000 -> res_valid, res_data=0x13FC, sp unchanged; LDRSP immed8=1 -> read addr 0x1004.
//  6. reset asserted while PUSH waits on ack -> outputs at reset values immediately, sp=SP_RESET, no done.

Source files
------------

// File: rtl/st_sp_sequencer_if.sv
// Signal bundle between instruction decode, the stack-pointer sequencer,
// the combinational stack adder and the data-memory port.
interface st_sp_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [7:0]  cmd_reglist;
  logic [6:0]  cmd_immed7;
  logic [7:0]  cmd_immed8;
  logic [31:0] cmd_data;
  logic [7:0]  dp_op_sel;
  logic [6:0]  dp_immed7;
  logic [7:0]  dp_immed8;
  logic [31:0] dp_data_in;
  logic [31:0] dp_data_out;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [2:0]  mem_reg;
  logic        mem_ack;
  logic [31:0] sp;
  logic        res_valid;
  logic [31:0] res_data;
  logic        done;
  logic        fault;

  modport master (
    output cmd_valid, cmd_op, cmd_reglist, cmd_immed7, cmd_immed8, cmd_data,
    output dp_data_out, mem_ack,
    input  cmd_ready, dp_op_sel, dp_immed7, dp_immed8, dp_data_in,
    input  mem_req, mem_we, mem_addr, mem_reg, sp, res_valid, res_data, done, fault
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_reglist, cmd_immed7, cmd_immed8, cmd_data,
    input  dp_data_out, mem_ack,
    output cmd_ready, dp_op_sel, dp_immed7, dp_immed8, dp_data_in,
    output mem_req, mem_we, mem_addr, mem_reg, sp, res_valid, res_data, done, fault
  );
endinterface

// File: rtl/st_sp_sequencer.sv
// Stack-pointer owner: sequences the external stack adder and expands
// PUSH/POP register lists into one memory word access per register.
//
// state | meaning
// IDLE  | ready for a command, adder idle (NOP)
// EXEC  | one-cycle adder op; SP/result captured at exit
// MEM   | memory access per listed register (or single LDRSP/STRSP)
// DONE  | one-cycle retire pulse, with res_valid/fault when applicable
module st_sp_sequencer #(
  parameter logic [31:0] SP_RESET = 32'h0000_1000,
  parameter logic [31:0] SP_LIMIT = 32'h0000_0800
) (
  input logic              clk,
  input logic              reset,
  st_sp_sequencer_if.slave bus
);
  localparam logic [7:0] OP_NOP   = 8'h00;
  localparam logic [7:0] OP_PUSH  = 8'h01;
  localparam logic [7:0] OP_POP   = 8'h02;
  localparam logic [7:0] OP_ADDSP = 8'h04;
  localparam logic [7:0] OP_SUBSP = 8'h08;
  localparam logic [7:0] OP_MOVSP = 8'h10;
  localparam logic [7:0] OP_ADDS  = 8'h20;
  localparam logic [7:0] OP_LDRSP = 8'h40;
  localparam logic [7:0] OP_STRSP = 8'h80;

  typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;

  state_t      state;
  logic [7:0]  op_q;
  logic [7:0]  mask_q;
  logic [31:0] data_q;
  logic [31:0] sp_q;
  logic [7:0]  dp_op_sel_q;
  logic [6:0]  immed7_q;
  logic [7:0]  immed8_q;
  logic [31:0] res_data_q;
  logic        cmd_ready_q;
  logic        res_valid_q;
  logic        done_q;
  logic        fault_q;

  logic        is_push;
  logic        is_pop;
  logic        is_ldst;
  logic [2:0]  push_idx;
  logic [2:0]  pop_idx;
  logic [2:0]  cur_idx;
  logic [7:0]  mask_next;
  logic        push_fault;
  logic        mem_active;

  assign is_push = (op_q == OP_PUSH);
  assign is_pop  = (op_q == OP_POP);
  assign is_ldst = (op_q == OP_LDRSP) || (op_q == OP_STRSP);

  // PUSH drains the mask from the top, POP from the bottom.
  always_comb begin
    push_idx = 3'd0;
    pop_idx  = 3'd0;
    for (int i = 0; i < 8; i++)
      if (mask_q[i]) push_idx = 3'(i);
    for (int i = 7; i >= 0; i--)
      if (mask_q[i]) pop_idx = 3'(i);
  end

  assign cur_idx   = is_push ? push_idx : (is_pop ? pop_idx : 3'd0);
  assign mask_next = mask_q & ~(8'b1 << cur_idx);

  // The limit check uses the adder's sp-4 result, so a faulting word never issues.
  assign push_fault = (state == MEM) && is_push && (bus.dp_data_out < SP_LIMIT);
  assign mem_active = (state == MEM) && !push_fault;

  assign bus.mem_req    = mem_active;
  assign bus.mem_we     = mem_active && (is_push || (op_q == OP_STRSP));
  assign bus.mem_addr   = !mem_active ? 32'h0 : (is_pop ? sp_q : bus.dp_data_out);
  assign bus.mem_reg    = mem_active ? cur_idx : 3'd0;

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.dp_op_sel  = dp_op_sel_q;
  assign bus.dp_immed7  = immed7_q;
  assign bus.dp_immed8  = immed8_q;
  assign bus.dp_data_in = sp_q;
  assign bus.sp         = sp_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.done       = done_q;
  assign bus.fault      = fault_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= OP_NOP;
      mask_q      <= 8'h00;
      data_q      <= 32'h0;
      sp_q        <= SP_RESET;
      dp_op_sel_q <= OP_NOP;
      immed7_q    <= 7'h00;
      immed8_q    <= 8'h00;
      res_data_q  <= 32'h0;
      cmd_ready_q <= 1'b1;
      res_valid_q <= 1'b0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            mask_q      <= bus.cmd_reglist;
            data_q      <= bus.cmd_data;
            immed7_q    <= bus.cmd_immed7;
            immed8_q    <= bus.cmd_immed8;
            dp_op_sel_q <= bus.cmd_op;
            cmd_ready_q <= 1'b0;
            if (((bus.cmd_op == OP_PUSH) || (bus.cmd_op == OP_POP)) && (bus.cmd_reglist != 8'h00))
              state <= MEM;
            else
              state <= EXEC;
          end
        end
        EXEC: begin
          case (op_q)
            OP_ADDSP, OP_SUBSP: sp_q <= bus.dp_data_out;
            OP_MOVSP:           sp_q <= data_q;
            OP_ADDS: begin
              res_data_q  <= bus.dp_data_out;
              res_valid_q <= 1'b1;
            end
            default: ;
          endcase
          if (is_ldst) begin
            mask_q <= 8'h01;
            state  <= MEM;
          end else begin
            done_q      <= 1'b1;
            dp_op_sel_q <= OP_NOP;
            state       <= DONE;
          end
        end
        MEM: begin
          if (push_fault) begin
            fault_q     <= 1'b1;
            done_q      <= 1'b1;
            dp_op_sel_q <= OP_NOP;
            state       <= DONE;
          end else if (bus.mem_ack) begin
            if (is_push || is_pop)
              sp_q <= bus.dp_data_out;
            mask_q <= mask_next;
            if (mask_next == 8'h00) begin
              done_q      <= 1'b1;
              dp_op_sel_q <= OP_NOP;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          done_q      <= 1'b0;
          fault_q     <= 1'b0;
          res_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
